// File: rtl/axi_rd_arbiter_if.sv
// AXI read address / read data channel bundle between the read arbiter and the
// AXI slave. The arbiter drives AR and rready; the slave drives arready and R.
interface axi_rd_arbiter_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arsize, arvalid, rready,
    input  arready, rid, rdata, rvalid
  );

  modport slave (
    input  arid, araddr, arsize, arvalid, rready,
    output arready, rid, rdata, rvalid
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Read-side scheduler: round-robin AR grant between instruction fetch and data
// load, per-ID outstanding limit, R routing by rid, and a pending-write address
// queue that holds back data loads hitting a write still awaiting its B response.
module axi_rd_arbiter #(
  parameter int MAX_OS   = 2,
  parameter int WQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [1:0]  data_size,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  input  logic        wr_issue,
  input  logic [31:0] wr_issue_addr,
  input  logic        wr_done,
  output logic        wq_full,
  axi_rd_arbiter_if.master axi
);

  localparam int PW = $clog2(WQ_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE = 1'b0, AR_WAIT = 1'b1} state_t;
  typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_t;

  state_t      state_q, state_d;
  owner_t      owner_q, last_grant_q;
  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic [1:0]  os_inst_q, os_data_q;

  logic [29:0]   wq_mem [WQ_DEPTH];
  logic [PW-1:0] wq_wr_ptr, wq_rd_ptr;
  logic [CW-1:0] wq_count;
  logic [PW-1:0] slot_off;

  logic       hazard, inst_elig, data_elig;
  logic       grant, grant_data;
  logic [2:0] data_arsize;
  logic       inst_ar_done, data_ar_done, inst_r, data_r;
  logic       push_en, pop_en;

  // Saturating outstanding counter: simultaneous +1/-1 cancels, never below 0.
  function automatic logic [1:0] next_os(input logic [1:0] cur, input logic inc,
                                         input logic dec);
    logic [1:0] res;
    res = cur;
    if (inc && !dec)
      res = cur + 2'd1;
    else if (dec && !inc && cur != 2'd0)
      res = cur - 2'd1;
    return res;
  endfunction

  // Size 3 is treated as a word access.
  assign data_arsize = (data_size == 2'd3) ? 3'd2 : {1'b0, data_size};

  // Hazard: data word address matches any occupied queue slot.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    hazard   = 1'b0;
    slot_off = '0;
    for (int i = 0; i < WQ_DEPTH; i++) begin
      slot_off = PW'(i) - wq_rd_ptr;
      if ({1'b0, slot_off} < wq_count && wq_mem[i] == data_addr[31:2])
        hazard = 1'b1;
    end
  end

  assign inst_elig = inst_req && (os_inst_q < 2'(MAX_OS));
  assign data_elig = data_req && (os_data_q < 2'(MAX_OS)) && !hazard;

  // Next-state, grant selection and AR/addr_ok outputs.
  always_comb begin
    state_d      = state_q;
    grant        = 1'b0;
    grant_data   = 1'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    axi.arvalid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (inst_elig || data_elig) begin
          grant      = 1'b1;
          grant_data = data_elig && (!inst_elig || last_grant_q == OWN_INST);
          state_d    = AR_WAIT;
        end
      end
      AR_WAIT: begin
        axi.arvalid = 1'b1;
        if (axi.arready) begin
          state_d      = IDLE;
          inst_addr_ok = (owner_q == OWN_INST);
          data_addr_ok = (owner_q == OWN_DATA);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Latch the granted request; held stable for the whole AR_WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= OWN_INST;
      last_grant_q <= OWN_INST;
      addr_q       <= '0;
      size_q       <= '0;
    end else if (grant) begin
      owner_q      <= grant_data ? OWN_DATA : OWN_INST;
      last_grant_q <= grant_data ? OWN_DATA : OWN_INST;
      addr_q       <= grant_data ? data_addr : inst_addr;
      size_q       <= grant_data ? data_arsize : 3'd2;
    end
  end

  assign axi.araddr = addr_q;
  assign axi.arsize = size_q;
  assign axi.arid   = {3'b000, owner_q == OWN_DATA};
  assign axi.rready = 1'b1;

  assign inst_ar_done = (state_q == AR_WAIT) && axi.arready && (owner_q == OWN_INST);
  assign data_ar_done = (state_q == AR_WAIT) && axi.arready && (owner_q == OWN_DATA);
  assign inst_r       = axi.rvalid && (axi.rid == 4'd0);
  assign data_r       = axi.rvalid && (axi.rid == 4'd1);

  assign inst_data_ok = inst_r;
  assign data_data_ok = data_r;
  assign inst_rdata   = axi.rdata;
  assign data_rdata   = axi.rdata;

  // Outstanding read counters per ID.
  always_ff @(posedge clk) begin
    if (rst) begin
      os_inst_q <= '0;
      os_data_q <= '0;
    end else begin
      os_inst_q <= next_os(os_inst_q, inst_ar_done, inst_r);
      os_data_q <= next_os(os_data_q, data_ar_done, data_r);
    end
  end

  // Writes complete in order, so the queue is a plain FIFO of word addresses.
  assign wq_full = (wq_count == CW'(WQ_DEPTH));
  assign pop_en  = wr_done && (wq_count != '0);
  assign push_en = wr_issue && (!wq_full || pop_en);

  // Queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wq_wr_ptr <= '0;
      wq_rd_ptr <= '0;
      wq_count  <= '0;
    end else begin
      if (push_en) wq_wr_ptr <= wq_wr_ptr + PW'(1);
      if (pop_en)  wq_rd_ptr <= wq_rd_ptr + PW'(1);
      if (push_en && !pop_en)      wq_count <= wq_count + CW'(1);
      else if (pop_en && !push_en) wq_count <= wq_count - CW'(1);
    end
  end

  // Queue storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; occupancy alone decides which slots are live,
    // so stale contents are never compared.
    if (push_en) wq_mem[wq_wr_ptr] <= wr_issue_addr[31:2];
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench: directed scenarios followed by random traffic, all
// compared each cycle against a transaction-level reference model.
module tb_axi_rd_arbiter;
  localparam int MAX_OS   = 2;
  localparam int WQ_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, data_req, wr_issue, wr_done;
  logic [31:0] inst_addr, data_addr, wr_issue_addr;
  logic [1:0]  data_size;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, wq_full;
  logic [31:0] inst_rdata, data_rdata;

  axi_rd_arbiter_if bus();

  axi_rd_arbiter #(.MAX_OS(MAX_OS), .WQ_DEPTH(WQ_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_addr(data_addr), .data_size(data_size),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .wr_issue(wr_issue), .wr_issue_addr(wr_issue_addr), .wr_done(wr_done),
    .wq_full(wq_full), .axi(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  bit          m_pend;
  bit          m_own;        // 0 = inst, 1 = data
  logic [31:0] m_addr;
  logic [2:0]  m_size;
  bit          m_last_data;
  int          m_os [2];
  logic [29:0] m_wq [$];
  bit          inst_acc, data_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_own = 0; m_addr = '0; m_size = '0; m_last_data = 0;
    m_os[0] = 0; m_os[1] = 0;
    m_wq.delete();
  endtask

  // Advance the model across one rising edge using the inputs seen this cycle.
  task automatic model_update();
    bit inst_el, data_el, haz, gd, pop_ok, push_ok;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_pend) begin
      if (bus.arready) begin
        m_os[m_own]++;
        m_pend = 0;
      end
    end else begin
      haz = 0;
      foreach (m_wq[i]) if (m_wq[i] == data_addr[31:2]) haz = 1;
      inst_el = inst_req && (m_os[0] < MAX_OS);
      data_el = data_req && (m_os[1] < MAX_OS) && !haz;
      if (inst_el || data_el) begin
        gd          = data_el && (!inst_el || !m_last_data);
        m_pend      = 1;
        m_own       = gd;
        m_last_data = gd;
        m_addr      = gd ? data_addr : inst_addr;
        m_size      = gd ? ((data_size == 2'd3) ? 3'd2 : {1'b0, data_size}) : 3'd2;
      end
    end
    if (bus.rvalid && bus.rid < 4'd2 && m_os[bus.rid[0]] > 0) m_os[bus.rid[0]]--;
    pop_ok  = wr_done && (m_wq.size() > 0);
    push_ok = wr_issue && ((m_wq.size() < WQ_DEPTH) || pop_ok);
    if (pop_ok)  void'(m_wq.pop_front());
    if (push_ok) m_wq.push_back(wr_issue_addr[31:2]);
  endtask

  // Compare all outputs mid-cycle, then move the model over the edge.
  task automatic step();
    bit exp_iok, exp_dok;
    @(negedge clk);
    exp_iok = m_pend && bus.arready && !m_own;
    exp_dok = m_pend && bus.arready && m_own;
    check("arvalid", bus.arvalid, m_pend);
    if (m_pend) begin
      check("araddr", bus.araddr, m_addr);
      check("arid", bus.arid, {3'b000, m_own});
      check("arsize", bus.arsize, m_size);
    end
    check("inst_addr_ok", inst_addr_ok, exp_iok);
    check("data_addr_ok", data_addr_ok, exp_dok);
    check("inst_data_ok", inst_data_ok, bus.rvalid && bus.rid == 4'd0);
    check("data_data_ok", data_data_ok, bus.rvalid && bus.rid == 4'd1);
    if (bus.rvalid && bus.rid == 4'd0) check("inst_rdata", inst_rdata, bus.rdata);
    if (bus.rvalid && bus.rid == 4'd1) check("data_rdata", data_rdata, bus.rdata);
    check("wq_full", wq_full, m_wq.size() == WQ_DEPTH);
    check("rready", bus.rready, 1'b1);
    if (wr_issue && !wr_done) check("wq_push_room", wq_full, 1'b0);
    inst_acc = exp_iok;
    data_acc = exp_dok;
    model_update();
    @(posedge clk);
    #1;
  endtask

  // Slave R channel: answer one outstanding read at random, or send a stray rid.
  task automatic drive_r(input int pct);
    int r;
    bus.rvalid = 1'b0;
    bus.rid    = 4'd0;
    bus.rdata  = $urandom;
    r = $urandom_range(0, 99);
    if (r < pct) begin
      if (m_os[0] > 0 && m_os[1] > 0) begin
        bus.rvalid = 1'b1; bus.rid = 4'($urandom_range(0, 1));
      end else if (m_os[0] > 0) begin
        bus.rvalid = 1'b1; bus.rid = 4'd0;
      end else if (m_os[1] > 0) begin
        bus.rvalid = 1'b1; bus.rid = 4'd1;
      end
    end else if (r < pct + 5) begin
      bus.rvalid = 1'b1; bus.rid = 4'($urandom_range(2, 15));
    end
  endtask

  // Stop requesting and let every outstanding read complete.
  task automatic drain();
    inst_req = 0; data_req = 0; wr_issue = 0; wr_done = 0;
    bus.arready = 1'b1;
    for (int k = 0; k < 40 && (m_pend || m_os[0] + m_os[1] > 0); k++) begin
      drive_r(100);
      step();
    end
    bus.rvalid = 1'b0;
  endtask

  task automatic rand_drive();
    if (!(inst_req && !inst_acc)) begin
      inst_req  = ($urandom_range(0, 99) < 50);
      inst_addr = $urandom & 32'hFFFF_FFFC;
    end else if ($urandom_range(0, 3) == 0) begin
      inst_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (!(data_req && !data_acc)) data_req = ($urandom_range(0, 99) < 50);
    data_addr = 32'h0000_2000 + 32'($urandom_range(0, 31));
    data_size = 2'($urandom_range(0, 3));
    wr_done   = ($urandom_range(0, 99) < 25);
    if (m_wq.size() < WQ_DEPTH) wr_issue = ($urandom_range(0, 99) < 25);
    else                        wr_issue = wr_done && ($urandom_range(0, 1) == 1);
    wr_issue_addr = 32'h0000_2000 + 32'($urandom_range(0, 7) << 2);
    bus.arready   = ($urandom_range(0, 99) < 70);
    drive_r(35);
  endtask

  initial begin
    rst = 1'b1;
    inst_req = 0; inst_addr = '0; data_req = 0; data_addr = '0; data_size = '0;
    wr_issue = 0; wr_issue_addr = '0; wr_done = 0;
    bus.arready = 1'b0; bus.rid = '0; bus.rdata = '0; bus.rvalid = 1'b0;
    inst_acc = 0; data_acc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset values.
    @(negedge clk);
    check("rst_arvalid", bus.arvalid, 1'b0);
    check("rst_arid", bus.arid, 4'd0);
    check("rst_araddr", bus.araddr, 32'd0);
    check("rst_arsize", bus.arsize, 3'd0);
    check("rst_inst_addr_ok", inst_addr_ok, 1'b0);
    check("rst_data_addr_ok", data_addr_ok, 1'b0);
    check("rst_wq_full", wq_full, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single fetch.
    inst_req = 1; inst_addr = 32'h1C00_0000; bus.arready = 1'b1;
    step();
    step();
    inst_req = 0;
    step();
    bus.rvalid = 1'b1; bus.rid = 4'd0; bus.rdata = 32'h0280_0C0C;
    step();
    bus.rvalid = 1'b0;

    // Tie: grants alternate data, inst, data.
    inst_req = 1; inst_addr = 32'h1C00_0004;
    data_req = 1; data_addr = 32'h0000_1004; data_size = 2'd0;
    repeat (6) step();
    drain();

    // Backpressure with inst_addr moving during the wait.
    inst_req = 1; inst_addr = 32'h1C00_0100; bus.arready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      inst_addr = 32'h1C00_0200 + 32'(i * 4);
      step();
    end
    bus.arready = 1'b1;
    step();
    inst_req = 0;
    drain();

    // Outstanding limit, then a same-cycle AR and R.
    inst_req = 1; bus.arready = 1'b1;
    repeat (6) step();
    bus.rvalid = 1'b1; bus.rid = 4'd0; bus.rdata = 32'hA5A5_0001;
    step();
    bus.rvalid = 1'b0;
    step();
    bus.rvalid = 1'b1; bus.rid = 4'd0; bus.rdata = 32'hA5A5_0002;
    step();
    bus.rvalid = 1'b0;
    repeat (3) step();
    drain();

    // Read-after-write hazard.
    wr_issue = 1; wr_issue_addr = 32'h0000_2008;
    step();
    wr_issue = 0;
    data_req = 1; data_addr = 32'h0000_200A; data_size = 2'd1;
    repeat (3) step();
    data_addr = 32'h0000_200C; data_size = 2'd2;
    repeat (2) step();
    data_addr = 32'h0000_200A; data_size = 2'd3;
    step();
    wr_done = 1;
    step();
    wr_done = 0;
    repeat (3) step();
    drain();

    // Queue full, same-cycle push/pop while full, empty, refill across the wrap.
    for (int i = 0; i < 4; i++) begin
      wr_issue = 1; wr_issue_addr = 32'h0000_3000 + 32'(i * 4);
      step();
    end
    wr_issue = 1; wr_done = 1; wr_issue_addr = 32'h0000_3010;
    step();
    wr_issue = 0;
    repeat (4) step();
    wr_done = 0;
    for (int i = 0; i < 4; i++) begin
      wr_issue = 1; wr_issue_addr = 32'h0000_4000 + 32'(i * 4);
      step();
    end
    wr_issue = 0;
    data_req = 1; data_addr = 32'h0000_4008; data_size = 2'd2; bus.arready = 1'b1;
    repeat (2) step();
    data_addr = 32'h0000_4010;
    repeat (2) step();
    data_req = 0;
    wr_done = 1;
    repeat (5) step();
    wr_done = 0;
    drain();

    // Reset mid-transaction; stray responses afterwards must not underflow.
    inst_req = 1; inst_addr = 32'h1C00_0300; bus.arready = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0; inst_req = 0;
    step();
    bus.rvalid = 1'b1; bus.rid = 4'd0; bus.rdata = 32'h1111_2222;
    step();
    bus.rid = 4'd1; bus.rdata = 32'h3333_4444;
    step();
    bus.rvalid = 1'b0;
    inst_req = 1; bus.arready = 1'b1;
    repeat (6) step();
    drain();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      rand_drive();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
